// File: rtl/test_status_monitor.sv
`default_nettype none
// ============================================================================
// Module   : test_status_monitor
// Purpose  : Watches a riscv-tests style program run and latches a sticky
//            verdict: pass, fail (with test number) or timeout.
//            MODE 0 looks for a full-word store to the tohost address.
//            MODE 1 looks for a retiring ecall and uses a shadow copy of the
//            GP register (with same-cycle bypass of a GP register write).
// Ports    : clk, rst_n (async, active low), clear (sync return to RUN)
//            mem_we/mem_addr/mem_wdata/mem_wstrb : data-memory write port
//            rf_we/rf_waddr/rf_wdata             : register-file write port
//            ecall_retire                        : ecall retires this cycle
//            done/pass/fail/timeout              : registered verdict flags
//            test_num                            : failing test number
//            cycle_count                         : saturating RUN cycle count
// Revision : 1.0 - initial release
// ============================================================================
module test_status_monitor #(
    parameter int          MODE           = 0,
    parameter logic [31:0] TOHOST_ADDR    = 32'h8000_1000,
    parameter int          GP_REG         = 3,
    parameter int          TIMEOUT_CYCLES = 10000,
    parameter int          CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             mem_we,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_wdata,
    input  logic [3:0]       mem_wstrb,
    input  logic             rf_we,
    input  logic [4:0]       rf_waddr,
    input  logic [31:0]      rf_wdata,
    input  logic             ecall_retire,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [30:0]      test_num,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    // The timeout compare is done at a width that can hold both the counter
    // and TIMEOUT_CYCLES-1, so a timeout beyond the counter's range simply
    // never fires instead of aliasing onto a truncated value.
    localparam int                 c_cmp_w        = (CNT_W > 32) ? CNT_W : 32;
    localparam logic [c_cmp_w-1:0] c_timeout_last = c_cmp_w'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]         c_gp_idx       = 5'(GP_REG);
    localparam logic               c_gp_valid     = (GP_REG != 0);

    state_t             r_state;
    state_t             w_state_next;
    logic [30:0]        r_test_num;
    logic [30:0]        w_test_num_next;
    logic [CNT_W-1:0]   r_cycle_count;
    logic [CNT_W-1:0]   w_count_next;
    logic               r_done;
    logic               r_pass;
    logic               r_fail;
    logic               r_timeout;

    logic               w_qualify;
    logic [31:0]        w_value;
    logic               w_event;
    logic [c_cmp_w-1:0] w_count_ext;
    logic               w_timeout_hit;

    // ------------------------------------------------------------------------
    // Candidate value selection
    // ------------------------------------------------------------------------
    generate
        if (MODE == 1) begin : g_mode_ecall
            logic [31:0] r_gp_shadow;
            logic        w_gp_write;
            logic        w_unused_mem;

            // x0 is hardwired, so a GP_REG of 0 never captures anything.
            assign w_gp_write = rf_we & (rf_waddr == c_gp_idx) & c_gp_valid;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_gp_shadow <= '0;
                end else if (clear) begin
                    r_gp_shadow <= '0;
                end else if (w_gp_write) begin
                    r_gp_shadow <= rf_wdata;
                end
            end

            assign w_qualify = ecall_retire;
            // The write that lands with the ecall is what the program sees.
            assign w_value   = w_gp_write ? rf_wdata : r_gp_shadow;

            assign w_unused_mem = ^{mem_we, mem_addr, mem_wdata, mem_wstrb};
        end else begin : g_mode_tohost
            logic w_unused_rf;

            assign w_qualify = mem_we & (mem_addr == TOHOST_ADDR) & (mem_wstrb == 4'hf);
            assign w_value   = mem_wdata;

            assign w_unused_rf = ^{rf_we, rf_waddr, rf_wdata, ecall_retire};
        end
    endgenerate

    // A zero candidate carries no verdict in either mode.
    assign w_event       = w_qualify & (w_value != 32'd0);
    assign w_count_ext   = c_cmp_w'(r_cycle_count);
    assign w_timeout_hit = (w_count_ext == c_timeout_last);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_test_num_next = r_test_num;
        if (clear) begin
            w_state_next    = ST_RUN;
            w_test_num_next = '0;
        end else if (r_state == ST_RUN) begin
            if (w_event) begin
                if (w_value == 32'd1) begin
                    w_state_next = ST_PASS;
                end else begin
                    w_state_next = ST_FAIL;
                    // An even non-zero code is malformed: report test 0.
                    w_test_num_next = w_value[0] ? w_value[31:1] : 31'd0;
                end
            end else if (w_timeout_hit) begin
                w_state_next = ST_TIMEOUT;
            end
        end
    end

    // The counter also steps on the edge that latches the verdict, then holds.
    always_comb begin
        w_count_next = r_cycle_count;
        if (clear) begin
            w_count_next = '0;
        end else if ((r_state == ST_RUN) && (r_cycle_count != {CNT_W{1'b1}})) begin
            w_count_next = r_cycle_count + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_RUN;
            r_test_num    <= '0;
            r_cycle_count <= '0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_fail        <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_test_num    <= w_test_num_next;
            r_cycle_count <= w_count_next;
            r_done        <= (w_state_next != ST_RUN);
            r_pass        <= (w_state_next == ST_PASS);
            r_fail        <= (w_state_next == ST_FAIL);
            r_timeout     <= (w_state_next == ST_TIMEOUT);
        end
    end

    assign done        = r_done;
    assign pass        = r_pass;
    assign fail        = r_fail;
    assign timeout     = r_timeout;
    assign test_num    = r_test_num;
    assign cycle_count = r_cycle_count;

endmodule
`default_nettype wire

// File: tb/tb_test_status_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_test_status_monitor
// Purpose  : Self-checking bench for test_status_monitor. Four instances with
//            different parameters share one stimulus stream; a behavioural
//            model per instance predicts every output on every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_test_status_monitor;

    localparam int          N      = 4;
    localparam logic [31:0] TOHOST = 32'h8000_1000;
    localparam int MODES [N] = '{0, 1, 0, 1};
    localparam int TMO   [N] = '{64, 64, 8, 100};
    localparam int CNTW  [N] = '{32, 32, 32, 3};
    localparam int GP    [N] = '{3, 3, 3, 3};

    localparam int V_RUN = 0, V_PASS = 1, V_FAIL = 2, V_TMO = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        ecall_retire;

    logic [N-1:0] done_v, pass_v, fail_v, tmo_v;
    logic [30:0]  tn_v [N];
    logic [31:0]  cc0, cc1, cc2;
    logic [2:0]   cc3;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    test_status_monitor #(.MODE(0), .TOHOST_ADDR(TOHOST), .GP_REG(3), .TIMEOUT_CYCLES(64), .CNT_W(32)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .ecall_retire(ecall_retire), .done(done_v[0]), .pass(pass_v[0]),
        .fail(fail_v[0]), .timeout(tmo_v[0]), .test_num(tn_v[0]), .cycle_count(cc0));

    test_status_monitor #(.MODE(1), .TOHOST_ADDR(TOHOST), .GP_REG(3), .TIMEOUT_CYCLES(64), .CNT_W(32)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .ecall_retire(ecall_retire), .done(done_v[1]), .pass(pass_v[1]),
        .fail(fail_v[1]), .timeout(tmo_v[1]), .test_num(tn_v[1]), .cycle_count(cc1));

    test_status_monitor #(.MODE(0), .TOHOST_ADDR(TOHOST), .GP_REG(3), .TIMEOUT_CYCLES(8), .CNT_W(32)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .clear(clear), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .ecall_retire(ecall_retire), .done(done_v[2]), .pass(pass_v[2]),
        .fail(fail_v[2]), .timeout(tmo_v[2]), .test_num(tn_v[2]), .cycle_count(cc2));

    test_status_monitor #(.MODE(1), .TOHOST_ADDR(TOHOST), .GP_REG(3), .TIMEOUT_CYCLES(100), .CNT_W(3)) u_dut_d (
        .clk(clk), .rst_n(rst_n), .clear(clear), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .ecall_retire(ecall_retire), .done(done_v[3]), .pass(pass_v[3]),
        .fail(fail_v[3]), .timeout(tmo_v[3]), .test_num(tn_v[3]), .cycle_count(cc3));

    // ------------------------------------------------------------------------
    // Behavioural model: verdict as an integer, counter as a plain number
    // ------------------------------------------------------------------------
    int          m_verdict [N] = '{0, 0, 0, 0};
    longint      m_cnt     [N] = '{0, 0, 0, 0};
    logic [30:0] m_tn      [N] = '{31'd0, 31'd0, 31'd0, 31'd0};
    logic [31:0] m_shadow  [N] = '{32'd0, 32'd0, 32'd0, 32'd0};

    task automatic model_step(input int i);
        bit          gpw;
        bit          ev;
        logic [31:0] v;
        longint      old;
        longint      maxc;
        maxc = (longint'(1) << CNTW[i]) - 1;
        gpw  = rf_we && (rf_waddr == 5'(GP[i])) && (GP[i] != 0);
        if (clear) begin
            m_verdict[i] = V_RUN;
            m_cnt[i]     = 0;
            m_shadow[i]  = 32'd0;
            m_tn[i]      = 31'd0;
        end else begin
            if (MODES[i] == 0) begin
                ev = mem_we && (mem_addr == TOHOST) && (mem_wstrb == 4'hf);
                v  = mem_wdata;
            end else begin
                ev = ecall_retire;
                v  = gpw ? rf_wdata : m_shadow[i];
            end
            if (v == 32'd0) ev = 1'b0;
            if (m_verdict[i] == V_RUN) begin
                old = m_cnt[i];
                if (m_cnt[i] < maxc) m_cnt[i] = m_cnt[i] + 1;
                if (ev) begin
                    if (v == 32'd1) begin
                        m_verdict[i] = V_PASS;
                    end else begin
                        m_verdict[i] = V_FAIL;
                        m_tn[i] = v[0] ? v[31:1] : 31'd0;
                    end
                end else if (old == longint'(TMO[i] - 1)) begin
                    m_verdict[i] = V_TMO;
                end
            end
            if (gpw) m_shadow[i] = rf_wdata;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_verdict[i] = V_RUN;
                m_cnt[i]     = 0;
                m_tn[i]      = 31'd0;
                m_shadow[i]  = 32'd0;
            end
        end else begin
            for (int i = 0; i < N; i++) model_step(i);
        end
    end

    // ------------------------------------------------------------------------
    // Per-cycle compare against the model
    // ------------------------------------------------------------------------
    task automatic check_inst(input int i, input logic d, input logic p, input logic f,
                              input logic t, input logic [30:0] tn, input longint cc);
        logic [3:0]  act;
        logic [3:0]  exp;
        logic [30:0] etn;
        act = {d, p, f, t};
        exp = {m_verdict[i] != V_RUN, m_verdict[i] == V_PASS,
               m_verdict[i] == V_FAIL, m_verdict[i] == V_TMO};
        etn = (m_verdict[i] == V_FAIL) ? m_tn[i] : 31'd0;
        checks++;
        if (act !== exp || tn !== etn || cc != m_cnt[i]) begin
            failures++;
            $display("FAIL model_dut%0d t=%0t flags(dpft) got=%b exp=%b test_num got=%0d exp=%0d cycle_count got=%0d exp=%0d",
                     i, $time, act, exp, tn, etn, cc, m_cnt[i]);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check_inst(0, done_v[0], pass_v[0], fail_v[0], tmo_v[0], tn_v[0], longint'(cc0));
            check_inst(1, done_v[1], pass_v[1], fail_v[1], tmo_v[1], tn_v[1], longint'(cc1));
            check_inst(2, done_v[2], pass_v[2], fail_v[2], tmo_v[2], tn_v[2], longint'(cc2));
            check_inst(3, done_v[3], pass_v[3], fail_v[3], tmo_v[3], tn_v[3], longint'(cc3));
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic lit(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle();
        clear = 1'b0; mem_we = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0; mem_wstrb = 4'h0;
        rf_we = 1'b0; rf_waddr = 5'd0; rf_wdata = 32'd0; ecall_retire = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        mem_we = 1'b1; mem_addr = addr; mem_wdata = data; mem_wstrb = strb;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    function automatic logic [31:0] rand_value();
        logic [31:0] r;
        case ($urandom_range(0, 4))
            0:       r = 32'd0;
            1:       r = 32'd1;
            2:       r = ($urandom_range(0, 1000) << 1) | 32'd1;
            3:       r = $urandom & 32'hffff_fffe;
            default: r = $urandom;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------------
    // Directed scenarios with hand-computed expectations, then random runs
    // ------------------------------------------------------------------------
    initial begin
        idle();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        cmp_en = 1'b1;
        tick();
        tick();
        lit("reset_done", longint'(done_v[0]), 0);
        lit("reset_count", longint'(cc0), 0);
        lit("reset_test_num", longint'(tn_v[0]), 0);
        rst_n = 1'b1;

        repeat (20) tick();
        lit("run20_count", longint'(cc0), 20);
        lit("run20_done", longint'(done_v[0]), 0);
        lit("tmo8_timeout", longint'(tmo_v[2]), 1);
        lit("tmo8_count", longint'(cc2), 8);
        lit("sat3_count", longint'(cc3), 7);

        mem_write(TOHOST, 32'd1, 4'hf);
        tick();
        idle();
        lit("pass_done", longint'(done_v[0]), 1);
        lit("pass_pass", longint'(pass_v[0]), 1);
        lit("pass_test_num", longint'(tn_v[0]), 0);
        lit("pass_count", longint'(cc0), 21);
        tick();
        tick();
        lit("pass_count_frozen", longint'(cc0), 21);

        do_clear();
        lit("clear_done", longint'(done_v[0]), 0);
        lit("clear_count", longint'(cc0), 0);
        mem_write(TOHOST, 32'h0000_0007, 4'hf);
        tick();
        idle();
        lit("fail_fail", longint'(fail_v[0]), 1);
        lit("fail_test_num", longint'(tn_v[0]), 3);
        mem_write(TOHOST, 32'd1, 4'hf);
        tick();
        idle();
        lit("sticky_fail", longint'(fail_v[0]), 1);
        lit("sticky_pass", longint'(pass_v[0]), 0);

        do_clear();
        lit("clear_fail_done", longint'(done_v[0]), 0);
        lit("clear_fail_count", longint'(cc0), 0);
        lit("clear_fail_test_num", longint'(tn_v[0]), 0);

        mem_write(TOHOST, 32'd1, 4'h1);
        tick();
        mem_write(TOHOST + 32'd4, 32'd1, 4'hf);
        tick();
        idle();
        lit("ignored_writes_done", longint'(done_v[0]), 0);

        do_clear();
        rf_we = 1'b1; rf_waddr = 5'd3; rf_wdata = 32'd1;
        tick();
        idle();
        ecall_retire = 1'b1;
        tick();
        idle();
        lit("ecall_pass", longint'(pass_v[1]), 1);

        do_clear();
        rf_we = 1'b1; rf_waddr = 5'd3; rf_wdata = 32'h15; ecall_retire = 1'b1;
        tick();
        idle();
        lit("bypass_fail", longint'(fail_v[1]), 1);
        lit("bypass_test_num", longint'(tn_v[1]), 10);

        do_clear();
        repeat (7) tick();
        mem_write(TOHOST, 32'd1, 4'hf);
        tick();
        idle();
        lit("last_cycle_pass", longint'(pass_v[2]), 1);
        lit("last_cycle_timeout", longint'(tmo_v[2]), 0);
        lit("last_cycle_count", longint'(cc2), 8);

        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        lit("async_rst_done", longint'(done_v[0]), 0);
        lit("async_rst_pass", longint'(pass_v[2]), 0);
        lit("async_rst_count", longint'(cc0), 0);
        tick();
        rst_n = 1'b1;

        for (int run = 0; run < 60; run++) begin
            do_clear();
            for (int c = 0; c < 80; c++) begin
                int r;
                clear  = ($urandom_range(0, 99) == 0);
                rst_n  = ($urandom_range(0, 199) != 0);
                mem_we = ($urandom_range(0, 99) < 8);
                r = $urandom_range(0, 99);
                if (r < 50)      mem_addr = TOHOST;
                else if (r < 70) mem_addr = TOHOST + 32'd4;
                else             mem_addr = $urandom;
                mem_wstrb    = ($urandom_range(0, 99) < 70) ? 4'hf : 4'($urandom);
                mem_wdata    = rand_value();
                rf_we        = ($urandom_range(0, 99) < 40);
                rf_waddr     = ($urandom_range(0, 99) < 40) ? 5'd3 : 5'($urandom);
                rf_wdata     = rand_value();
                ecall_retire = ($urandom_range(0, 99) < 4);
                tick();
            end
            idle();
            rst_n = 1'b1;
        end

        tick();
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
